// File: rtl/trap_ctrl.sv
// trap_ctrl: commit-stage trap arbiter plus core-local timer (mtime/mtimecmp).
// Produces a one-cycle registered exception pulse toward the CSR unit, stalls
// commit around the redirect, and serves the CLINT timer registers on a simple bus.
module trap_ctrl #(
    parameter logic [15:0] CLINT_MTIMECMP = 16'h4000,
    parameter logic [15:0] CLINT_MTIME    = 16'hBFF8,
    // Cause value handed to the CSR unit for mret (shared encoding with the CSR unit)
    parameter logic [4:0]  MRET_CAUSE     = 5'b11111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_valid,
    input  logic [63:0] commit_pc,
    input  logic        commit_ecall,
    input  logic        commit_ebreak,
    input  logic        commit_illegal,
    input  logic        commit_mret,
    input  logic        mstatus_mie,
    input  logic        mie_mtie,
    input  logic        clint_ren,
    input  logic        clint_wen,
    input  logic [15:0] clint_addr,
    input  logic [63:0] clint_wdata,
    output logic [63:0] clint_rdata,
    output logic        exception_flag,
    output logic [4:0]  exception_cause,
    output logic [63:0] epc,
    output logic        flush,
    output logic        stall,
    output logic        mip_mtip
);

    localparam logic [4:0] CAUSE_MTI     = 5'b10111;
    localparam logic [4:0] CAUSE_ILLEGAL = 5'b00010;
    localparam logic [4:0] CAUSE_EBREAK  = 5'b00011;
    localparam logic [4:0] CAUSE_ECALL   = 5'b01011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRAP  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_q;
    logic        flag_q;
    logic        stall_q;
    logic [4:0]  cause_q;
    logic [63:0] epc_q;

    logic [63:0] mtime_q;
    logic [63:0] mtime_d;
    logic [63:0] mtimecmp_q;
    logic [63:0] mtimecmp_d;
    logic        mip_q;
    logic [63:0] rdata_q;
    logic [63:0] rdata_d;

    logic        irq_pending;
    logic        sync_pending;
    logic        take_trap;
    logic [4:0]  cause_sel;
    logic        wr_mtime;
    logic        wr_mtimecmp;

    // Trap request seen at commit while idle; the interrupt uses the registered MTIP level
    assign irq_pending  = mip_q & mie_mtie & mstatus_mie;
    assign sync_pending = commit_illegal | commit_ebreak | commit_ecall | commit_mret;
    assign take_trap    = (state_q == IDLE) & commit_valid & (irq_pending | sync_pending);

    assign wr_mtime    = clint_wen & (clint_addr == CLINT_MTIME);
    assign wr_mtimecmp = clint_wen & (clint_addr == CLINT_MTIMECMP);

    // Priority select of the trap cause: interrupt first, then illegal, ebreak, ecall, mret
    always_comb begin
        cause_sel = MRET_CAUSE;
        if (irq_pending)
            cause_sel = CAUSE_MTI;
        else if (commit_illegal)
            cause_sel = CAUSE_ILLEGAL;
        else if (commit_ebreak)
            cause_sel = CAUSE_EBREAK;
        else if (commit_ecall)
            cause_sel = CAUSE_ECALL;
    end

    // Trap FSM: IDLE -> TRAP (pulse) -> DRAIN -> IDLE, latching cause/epc on entry
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            flag_q  <= 1'b0;
            stall_q <= 1'b0;
            cause_q <= 5'd0;
            epc_q   <= 64'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (take_trap) begin
                        state_q <= TRAP;
                        flag_q  <= 1'b1;
                        stall_q <= 1'b1;
                        cause_q <= cause_sel;
                        epc_q   <= commit_pc;
                    end else begin
                        flag_q  <= 1'b0;
                        stall_q <= 1'b0;
                    end
                end
                TRAP: begin
                    state_q <= DRAIN;
                    flag_q  <= 1'b0;
                    stall_q <= 1'b1;
                end
                DRAIN: begin
                    state_q <= IDLE;
                    flag_q  <= 1'b0;
                    stall_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    flag_q  <= 1'b0;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

    // Next values of the timer registers: bus write overrides the free-running increment
    always_comb begin
        mtime_d    = wr_mtime ? clint_wdata : mtime_q + 64'd1;
        mtimecmp_d = wr_mtimecmp ? clint_wdata : mtimecmp_q;
    end

    // Timer registers; MTIP compares the pre-update values, so it lags one edge
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_q    <= 64'd0;
            mtimecmp_q <= '1;
            mip_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            mip_q      <= (mtime_q >= mtimecmp_q);
        end
    end

    // Read mux over the current (old) register values; unmapped offsets read zero
    always_comb begin
        rdata_d = rdata_q;
        if (clint_ren) begin
            if (clint_addr == CLINT_MTIME)
                rdata_d = mtime_q;
            else if (clint_addr == CLINT_MTIMECMP)
                rdata_d = mtimecmp_q;
            else
                rdata_d = 64'd0;
        end
    end

    // Registered bus read data, held between reads
    always_ff @(posedge clk) begin
        if (rst)
            rdata_q <= 64'd0;
        else
            rdata_q <= rdata_d;
    end

    assign exception_flag  = flag_q;
    assign flush           = flag_q;
    assign exception_cause = cause_q;
    assign epc             = epc_q;
    assign stall           = stall_q | take_trap;
    assign mip_mtip        = mip_q;
    assign clint_rdata     = rdata_q;

endmodule
